// File: rtl/hazard_interlock_if.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_interlock_if
//  Description : OF-stage operand fields, flush and interlock results that are
//                exchanged between decode/pipeline control and the interlock.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hazard_interlock_if #(
    parameter int CNT_W = 16
);
    logic             of_valid;
    logic [4:0]       of_opcode;
    logic             of_imm;
    logic [3:0]       of_rs1;
    logic [3:0]       of_rs2;
    logic [3:0]       of_rd;
    logic [3:0]       of_ra;
    logic             flush;
    logic             stall;
    logic             ex_bubble;
    logic [CNT_W-1:0] stall_count;

    // Pipeline control side: presents the OF instruction, receives the verdict
    modport master (
        output of_valid, of_opcode, of_imm, of_rs1, of_rs2, of_rd, of_ra, flush,
        input  stall, ex_bubble, stall_count
    );

    // Interlock side
    modport slave (
        input  of_valid, of_opcode, of_imm, of_rs1, of_rs2, of_rd, of_ra, flush,
        output stall, ex_bubble, stall_count
    );
endinterface
`default_nettype wire

// File: rtl/hazard_interlock.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_interlock
//  Description : RAW interlock for the 5-stage SimpleRISC pipeline without
//                forwarding. Tracks writers in EX/MA/RW, stalls IF/OF while the
//                OF instruction reads a pending destination, injects EX bubbles
//                and keeps a saturating count of stall cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_interlock #(
    parameter int CHECK_DEPTH = 3,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_interlock_if.slave bus
);
    localparam int c_STAGES = 3;
    localparam int c_SRCS   = 4;

    typedef struct packed {
        logic       valid;
        logic       wr;
        logic [3:0] dst;
    } entry_t;

    // Index 0 = EX, 1 = MA, 2 = RW
    entry_t [c_STAGES-1:0] pipe_q, pipe_d;
    logic                  ex_bubble_q, ex_bubble_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  w_rd_rs1, w_rd_rs2, w_rd_rdsrc, w_rd_ra;
    logic                  w_wr_rd, w_wr_ra;
    logic [c_SRCS-1:0]     w_src_en;
    logic [3:0]            w_src_reg [c_SRCS];
    logic [c_STAGES-1:0]   w_stage_hit;
    logic                  w_hazard, w_stall, w_issue;

    // Operand usage decoded from the opcode; unused fields are masked out here
    always_comb begin
        w_rd_rs1    = bus.of_opcode inside {[5'd0:5'd7], [5'd10:5'd12], 5'd14, 5'd15};
        w_rd_rs2    = !bus.of_imm && (bus.of_opcode inside {[5'd0:5'd12], 5'd24, 5'd25});
        w_rd_rdsrc  = (bus.of_opcode == 5'd15);
        w_rd_ra     = (bus.of_opcode == 5'd20);
        w_wr_rd     = bus.of_opcode inside {[5'd0:5'd4], [5'd6:5'd12], 5'd14, 5'd24, 5'd25};
        w_wr_ra     = (bus.of_opcode == 5'd19);
    end

    assign w_src_en     = {w_rd_ra, w_rd_rdsrc, w_rd_rs2, w_rd_rs1};
    assign w_src_reg[0] = bus.of_rs1;
    assign w_src_reg[1] = bus.of_rs2;
    assign w_src_reg[2] = bus.of_rd;
    assign w_src_reg[3] = bus.of_ra;

    // Per-stage conflict detection; stages beyond CHECK_DEPTH never conflict
    for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
        if (k < CHECK_DEPTH) begin : g_chk
            logic [c_SRCS-1:0] w_match;
            for (genvar s = 0; s < c_SRCS; s++) begin : g_src
                assign w_match[s] = w_src_en[s] && (w_src_reg[s] == pipe_q[k].dst);
            end
            assign w_stage_hit[k] = pipe_q[k].valid && pipe_q[k].wr && (|w_match);
        end else begin : g_off
            assign w_stage_hit[k] = 1'b0;
        end
    end

    // Flush kills the OF instruction, so it overrides any stall request
    assign w_hazard = |w_stage_hit;
    assign w_stall  = bus.of_valid && !bus.flush && w_hazard;
    assign w_issue  = bus.of_valid && !w_stall && !bus.flush;

    // Next state: shift chain advances every cycle, a bubble enters EX unless OF issues
    always_comb begin
        pipe_d          = pipe_q;
        pipe_d[0].valid = w_issue;
        pipe_d[0].wr    = w_issue && (w_wr_rd || w_wr_ra);
        pipe_d[0].dst   = 4'd0;
        if (w_issue && w_wr_rd) begin
            pipe_d[0].dst = bus.of_rd;
        end else if (w_issue && w_wr_ra) begin
            pipe_d[0].dst = bus.of_ra;
        end
        pipe_d[1]   = pipe_q[0];
        pipe_d[2]   = pipe_q[1];
        ex_bubble_d = !w_issue;
        cnt_d       = cnt_q;
        if (w_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State registers; reset empties the tracker and marks EX as a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q      <= '0;
            ex_bubble_q <= 1'b1;
            cnt_q       <= '0;
        end else begin
            pipe_q      <= pipe_d;
            ex_bubble_q <= ex_bubble_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.stall       = w_stall;
    assign bus.ex_bubble   = ex_bubble_q;
    assign bus.stall_count = cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_hazard_interlock.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_hazard_interlock
//  Description : Self-checking bench for hazard_interlock: directed scenarios
//                plus randomized instruction streams against a reference model
//                built from the register-usage table and a history of writers.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_interlock;
    localparam int DEPTH = 3;
    localparam int CW    = 8;              // narrow counter so saturation is reachable quickly
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_interlock_if #(.CNT_W(CW)) bus();

    hazard_interlock #(.CHECK_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Usage table as opcode bitmaps (bit n set = opcode n has that usage)
    bit [31:0] u_rs1   = 32'h0000_DCFF;
    bit [31:0] u_rs2   = 32'h0300_1FFF;
    bit [31:0] u_rdsrc = 32'h0000_8000;
    bit [31:0] u_rars  = 32'h0010_0000;
    bit [31:0] u_wrd   = 32'h0300_5FDF;
    bit [31:0] u_wra   = 32'h0008_0000;

    int checks = 0;
    int errors = 0;
    int hist[$];          // destinations written by the last issue slots, newest first; -1 = none
    bit m_stall;
    bit m_bub;
    int m_cnt;
    bit obs_stall;

    function automatic bit [15:0] read_mask(input logic [4:0] op, input logic imm,
                                            input logic [3:0] r1, input logic [3:0] r2,
                                            input logic [3:0] rd);
        bit [15:0] m;
        m = '0;
        if (u_rs1[op])           m[r1] = 1'b1;
        if (u_rs2[op] && !imm)   m[r2] = 1'b1;
        if (u_rdsrc[op])         m[rd] = 1'b1;
        if (u_rars[op])          m[15] = 1'b1;
        return m;
    endfunction

    function automatic int write_dst(input logic [4:0] op, input logic [3:0] rd);
        if (u_wrd[op]) return int'(rd);
        if (u_wra[op]) return 15;
        return -1;
    endfunction

    task automatic idle();
        bus.of_valid  = 1'b0;
        bus.of_opcode = 5'd13;
        bus.of_imm    = 1'b0;
        bus.of_rs1    = 4'd0;
        bus.of_rs2    = 4'd0;
        bus.of_rd     = 4'd0;
        bus.of_ra     = 4'd15;
        bus.flush     = 1'b0;
    endtask

    // One clock of the pipeline: compare the combinational stall, advance, compare registered outputs
    task automatic step();
        bit [15:0] rm;
        bit        hz;
        bit        iss;
        int        wd;
        #1;
        rm = read_mask(bus.of_opcode, bus.of_imm, bus.of_rs1, bus.of_rs2, bus.of_rd);
        hz = 1'b0;
        for (int k = 0; k < hist.size() && k < DEPTH; k++)
            if (hist[k] >= 0 && rm[hist[k]]) hz = 1'b1;
        m_stall   = bus.of_valid && !bus.flush && hz;
        obs_stall = bus.stall;
        checks++;
        if (bus.stall !== m_stall) begin
            errors++;
            $display("FAIL stall @%0t: got %b expected %b", $time, bus.stall, m_stall);
        end
        iss = bus.of_valid && !m_stall && !bus.flush;
        wd  = iss ? write_dst(bus.of_opcode, bus.of_rd) : -1;
        @(posedge clk);
        #1;
        hist.push_front(wd);
        if (hist.size() > 3) void'(hist.pop_back());
        m_bub = !iss;
        if (m_stall && m_cnt < CMAX) m_cnt++;
        checks++;
        if (bus.ex_bubble !== m_bub) begin
            errors++;
            $display("FAIL ex_bubble @%0t: got %b expected %b", $time, bus.ex_bubble, m_bub);
        end
        checks++;
        if (bus.stall_count !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL stall_count @%0t: got %0d expected %0d", $time, bus.stall_count, m_cnt);
        end
    endtask

    // Present one instruction in OF and hold it until the interlock lets it go
    task automatic issue(input logic [4:0] op, input logic imm, input logic [3:0] r1,
                         input logic [3:0] r2, input logic [3:0] rd,
                         output int nst, output int nbub);
        bit done;
        nst  = 0;
        nbub = 0;
        done = 1'b0;
        bus.of_valid  = 1'b1;
        bus.of_opcode = op;
        bus.of_imm    = imm;
        bus.of_rs1    = r1;
        bus.of_rs2    = r2;
        bus.of_rd     = rd;
        bus.of_ra     = 4'd15;
        bus.flush     = 1'b0;
        for (int i = 0; i < 8 && !done; i++) begin
            step();
            if (!obs_stall) done = 1'b1;
            else begin
                nst++;
                if (bus.ex_bubble === 1'b1) nbub++;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout op=%0d: stalled %0d cycles, required release", op, nst);
        end
        idle();
    endtask

    task automatic nop();
        int a, b;
        issue(5'd13, 1'b0, 4'd0, 4'd0, 4'd0, a, b);
    endtask

    task automatic apply_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b required 0", bus.stall);
        end
        checks++;
        if (bus.ex_bubble !== 1'b1) begin
            errors++; $display("FAIL reset_bubble: got %b required 1", bus.ex_bubble);
        end
        checks++;
        if (bus.stall_count !== '0) begin
            errors++; $display("FAIL reset_count: got %0d required 0", bus.stall_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hist.delete();
        m_bub = 1'b1;
        m_cnt = 0;
    endtask

    task automatic test_reset();
        int ns, nb;
        apply_reset();
        step();
        // reader of r1 right after reset: nothing in EX yet, so no stall
        issue(5'd1, 1'b0, 4'd1, 4'd5, 4'd4, ns, nb);
        checks++;
        if (ns !== 0) begin
            errors++; $display("FAIL post_reset_stall: got %0d required 0", ns);
        end
    endtask

    task automatic test_back_to_back();
        int ns, nb;
        apply_reset();
        issue(5'd0, 1'b0, 4'd2, 4'd3, 4'd1, ns, nb);     // add r1,r2,r3
        issue(5'd1, 1'b0, 4'd1, 4'd5, 4'd4, ns, nb);     // sub r4,r1,r5
        checks++;
        if (ns !== DEPTH) begin
            errors++; $display("FAIL b2b_stalls: got %0d required %0d", ns, DEPTH);
        end
        checks++;
        if (nb !== DEPTH) begin
            errors++; $display("FAIL b2b_bubbles: got %0d required %0d", nb, DEPTH);
        end
        checks++;
        if (bus.stall_count !== CW'(DEPTH)) begin
            errors++; $display("FAIL b2b_count: got %0d required %0d", bus.stall_count, DEPTH);
        end
    endtask

    task automatic test_distance();
        int ns, nb;
        for (int n = 0; n <= 3; n++) begin
            apply_reset();
            issue(5'd0, 1'b0, 4'd2, 4'd3, 4'd1, ns, nb);
            for (int j = 0; j < n; j++) nop();
            issue(5'd1, 1'b0, 4'd1, 4'd5, 4'd4, ns, nb);
            checks++;
            if (ns !== DEPTH - n) begin
                errors++; $display("FAIL distance_%0d: got %0d stalls required %0d", n, ns, DEPTH - n);
            end
        end
    endtask

    task automatic test_imm_operand();
        int ns, nb;
        apply_reset();
        issue(5'd0, 1'b0, 4'd3, 4'd4, 4'd1, ns, nb);     // add r1,r3,r4
        issue(5'd0, 1'b1, 4'd2, 4'd1, 4'd7, ns, nb);     // add r7,r2,#imm (rs2 field = r1)
        checks++;
        if (ns !== 0) begin
            errors++; $display("FAIL imm_no_stall: got %0d required 0", ns);
        end
        issue(5'd0, 1'b0, 4'd3, 4'd4, 4'd1, ns, nb);     // add r1,r3,r4
        issue(5'd9, 1'b0, 4'd0, 4'd1, 4'd6, ns, nb);     // mov r6,r1
        checks++;
        if (ns !== DEPTH) begin
            errors++; $display("FAIL mov_reg_stall: got %0d required %0d", ns, DEPTH);
        end
    endtask

    task automatic test_call_ret_st();
        int ns, nb;
        apply_reset();
        issue(5'd19, 1'b0, 4'd0, 4'd0, 4'd0, ns, nb);    // call
        issue(5'd20, 1'b0, 4'd0, 4'd0, 4'd0, ns, nb);    // ret
        checks++;
        if (ns !== DEPTH) begin
            errors++; $display("FAIL ret_after_call: got %0d required %0d", ns, DEPTH);
        end
        issue(5'd0, 1'b0, 4'd2, 4'd3, 4'd1, ns, nb);     // add r1,r2,r3
        issue(5'd15, 1'b1, 4'd2, 4'd0, 4'd1, ns, nb);    // st r1,[r2]
        checks++;
        if (ns !== DEPTH) begin
            errors++; $display("FAIL st_rd_source: got %0d required %0d", ns, DEPTH);
        end
    endtask

    task automatic test_flush();
        int ns, nb;
        apply_reset();
        issue(5'd0, 1'b0, 4'd2, 4'd3, 4'd1, ns, nb);
        bus.of_valid  = 1'b1;
        bus.of_opcode = 5'd1;
        bus.of_rs1    = 4'd1;
        bus.of_rs2    = 4'd5;
        bus.of_rd     = 4'd4;
        bus.flush     = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall: got %b required 0", bus.stall);
        end
        step();
        checks++;
        if (bus.ex_bubble !== 1'b1) begin
            errors++; $display("FAIL flush_bubble: got %b required 1", bus.ex_bubble);
        end
        checks++;
        if (bus.stall_count !== '0) begin
            errors++; $display("FAIL flush_count: got %0d required 0", bus.stall_count);
        end
        idle();
        step();
    endtask

    task automatic test_random();
        bit hold;
        apply_reset();
        hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bus.flush = ($urandom_range(0, 9) == 0);
            if (!hold) begin
                bus.of_valid  = ($urandom_range(0, 99) < 85);
                bus.of_opcode = 5'($urandom_range(0, 31));
                bus.of_imm    = 1'($urandom_range(0, 1));
                bus.of_rs1    = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                bus.of_rs2    = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                bus.of_rd     = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
                bus.of_ra     = 4'd15;
            end
            step();
            hold = m_stall;
        end
        idle();
    endtask

    task automatic test_saturation();
        int ns, nb, total;
        apply_reset();
        total = 0;
        for (int i = 0; i < 200 && total < (1 << CW) + 5; i++) begin
            issue(5'd0, 1'b0, 4'd1, 4'd1, 4'd1, ns, nb);   // add r1,r1,r1 chain
            total += ns;
        end
        checks++;
        if (bus.stall_count !== CW'(CMAX)) begin
            errors++; $display("FAIL saturation: got %0d required %0d after %0d stalls", bus.stall_count, CMAX, total);
        end
    endtask

    task automatic test_reset_mid_stall();
        int ns, nb;
        apply_reset();
        issue(5'd0, 1'b0, 4'd2, 4'd3, 4'd1, ns, nb);
        bus.of_valid  = 1'b1;
        bus.of_opcode = 5'd1;
        bus.of_rs1    = 4'd1;
        bus.of_rs2    = 4'd5;
        bus.of_rd     = 4'd4;
        step();                                           // first stall cycle
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL midreset_stall: got %b required 0", bus.stall);
        end
        checks++;
        if (bus.stall_count !== '0) begin
            errors++; $display("FAIL midreset_count: got %0d required 0", bus.stall_count);
        end
        checks++;
        if (bus.ex_bubble !== 1'b1) begin
            errors++; $display("FAIL midreset_bubble: got %b required 1", bus.ex_bubble);
        end
        apply_reset();
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_back_to_back();
        test_distance();
        test_imm_operand();
        test_call_ret_st();
        test_flush();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
